led_btn_mmio: RTL

- Memory-mapped LED/button peripheral on the CPU data bus. Uses the same addr/wdata/wmask/wstrb/rstrb/rdata/rbusy/wbusy handshake as the ram block.
- Replaces the ad-hoc free-running LED counter and raw button sampling with:
  - NCH PWM-dimmed LED channels
  - a debounced button with press counter and interrupt pulse
  - a generic 32-bit event counter

---
 rtl/led_btn_mmio.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/led_btn_mmio.sv
// Bus-mapped LED/button peripheral: NCH PWM LED channels, debounced button with press counter and irq.
// Define LED_BTN_EVCNT_EN to build the EVCNT register and make ev_strb functional.

module led_pwm_lane #(
  parameter int PWM_W   = 8,
  parameter int INV_RST = 1
) (
  input  logic             clk48,
  input  logic             rst_n,
  input  logic             we,
  input  logic [PWM_W-1:0] wd,
  input  logic [PWM_W-1:0] wbits,
  input  logic             en,
  input  logic             inv,
  input  logic             load,
  input  logic [PWM_W-1:0] cnt,
  output logic [PWM_W-1:0] duty,
  output logic             pwm
);
  logic [PWM_W-1:0] shadow;

  // shadow only follows duty at period boundaries (or while disabled) so edits never cut a pulse short
  always_ff @(posedge clk48 or negedge rst_n)
    if (!rst_n) begin
      duty   <= '0;
      shadow <= '0;
      pwm    <= 1'(INV_RST);
    end else begin
      if (we)   duty   <= (duty & ~wbits) | (wd & wbits);
      if (load) shadow <= duty;
      pwm <= (en && (cnt < shadow)) ^ inv;
    end
endmodule

module led_btn_mmio #(
  parameter int NCH        = 3,
  parameter int PWM_W      = 8,
  parameter int DEB_CYCLES = 480000,
  parameter int INV_RST    = 1
) (
  input  logic           clk48,
  input  logic           rst_n,
  input  logic [31:0]    addr,
  input  logic [31:0]    wdata,
  input  logic [3:0]     wmask,
  input  logic           wstrb,
  input  logic           rstrb,
  output logic [31:0]    rdata,
  output logic           rbusy,
  output logic           wbusy,
  input  logic           btn_in,
  input  logic           ev_strb,
  output logic [NCH-1:0] pwm_out,
  output logic           btn_irq
);
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam logic [3:0] A_CTRL  = 4'd0;
  localparam logic [3:0] A_PRESC = 4'd1;
  localparam logic [3:0] A_DUTY0 = 4'd2;
  localparam logic [3:0] A_BTN   = 4'd8;
  localparam logic [3:0] A_EVCNT = 4'd9;

  logic [3:0]  off;
  logic [31:0] wbits;
  assign off   = addr[5:2];
  assign wbits = {{8{wmask[3]}}, {8{wmask[2]}}, {8{wmask[1]}}, {8{wmask[0]}}};
  assign rbusy = 1'b0;
  assign wbusy = 1'b0;

  logic        ctrl_en, ctrl_inv;
  logic [15:0] presc;

  always_ff @(posedge clk48 or negedge rst_n)
    if (!rst_n) begin
      ctrl_en  <= 1'b0;
      ctrl_inv <= 1'(INV_RST);
      presc    <= '0;
    end else if (wstrb) begin
      if (off == A_CTRL && wmask[0]) {ctrl_inv, ctrl_en} <= wdata[1:0];
      if (off == A_PRESC) presc <= (presc & ~wbits[15:0]) | (wdata[15:0] & wbits[15:0]);
    end

  logic [15:0]      pcnt;
  logic [PWM_W-1:0] cnt;
  logic             tick, load;
  assign tick = ctrl_en && (pcnt == presc);
  assign load = !ctrl_en || (tick && (cnt == {PWM_W{1'b1}}));

  always_ff @(posedge clk48 or negedge rst_n)
    if (!rst_n) begin
      pcnt <= '0;
      cnt  <= '0;
    end else if (!ctrl_en) begin
      pcnt <= '0;
      cnt  <= '0;
    end else begin
      pcnt <= tick ? '0 : pcnt + 16'd1;
      if (tick) cnt <= cnt + PWM_W'(1);
    end

  logic [NCH-1:0]            duty_we;
  logic [NCH-1:0][PWM_W-1:0] duty;

  for (genvar i = 0; i < NCH; i++) begin : g_lane
    assign duty_we[i] = wstrb && (off == 4'(A_DUTY0 + i));
    led_pwm_lane #(.PWM_W(PWM_W), .INV_RST(INV_RST)) u_lane (
      .clk48 (clk48),
      .rst_n (rst_n),
      .we    (duty_we[i]),
      .wd    (wdata[PWM_W-1:0]),
      .wbits (wbits[PWM_W-1:0]),
      .en    (ctrl_en),
      .inv   (ctrl_inv),
      .load  (load),
      .cnt   (cnt),
      .duty  (duty[i]),
      .pwm   (pwm_out[i])
    );
  end

  logic          sync1, sync2, lvl, mism, flip, btn_clr;
  logic [DW-1:0] deb_cnt;
  logic [7:0]    press;
  assign mism    = sync2 ^ lvl;
  assign flip    = mism && (deb_cnt == DW'(DEB_CYCLES - 1));
  assign btn_clr = wstrb && (off == A_BTN) && (|wmask);

  always_ff @(posedge clk48 or negedge rst_n)
    if (!rst_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      lvl     <= 1'b0;
      deb_cnt <= '0;
      press   <= '0;
      btn_irq <= 1'b0;
    end else begin
      sync1   <= btn_in;
      sync2   <= sync1;
      deb_cnt <= (mism && !flip) ? deb_cnt + DW'(1) : '0;
      if (flip) lvl <= ~lvl;
      btn_irq <= flip && !lvl;
      // a clearing write beats a press landing on the same edge
      if (btn_clr)           press <= '0;
      else if (flip && !lvl) press <= press + 8'd1;
    end

  logic [31:0] evcnt;
`ifdef LED_BTN_EVCNT_EN
  always_ff @(posedge clk48 or negedge rst_n)
    if (!rst_n)                         evcnt <= '0;
    else if (wstrb && off == A_EVCNT)   evcnt <= (evcnt & ~wbits) | (wdata & wbits);
    else if (ev_strb)                   evcnt <= evcnt + 32'd1;
`else
  assign evcnt = '0;
`endif

  logic [31:0] rd;
  always_comb begin
    rd = '0;
    case (off)
      A_CTRL:  rd = {30'b0, ctrl_inv, ctrl_en};
      A_PRESC: rd = {16'b0, presc};
      A_BTN:   rd = {16'b0, press, 7'b0, lvl};
      A_EVCNT: rd = evcnt;
      default:
        for (int i = 0; i < NCH; i++)
          if (off == 4'(A_DUTY0 + i)) rd = 32'(duty[i]);
    endcase
  end

  // rd reflects state before this edge, so a same-cycle write returns the old value
  always_ff @(posedge clk48 or negedge rst_n)
    if (!rst_n)     rdata <= '0;
    else if (rstrb) rdata <= rd;

  logic unused;
  assign unused = ^{addr, wdata, wbits, ev_strb};
endmodule
